// File: rtl/uart_word_packer.sv
// uart_word_packer: packs received bytes into wide words with keep mask, flush/timeout and drop counting
module uart_word_packer #(
  parameter int BYTE_W         = 8,
  parameter int BYTES_PER_WORD = 16,
  parameter int LITTLE_ENDIAN  = 1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int DROP_CNT_W     = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [BYTE_W-1:0]                in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             flush,
  output logic [BYTE_W*BYTES_PER_WORD-1:0] out_data,
  output logic [BYTES_PER_WORD-1:0]        out_keep,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DROP_CNT_W-1:0]            drop_cnt
);
  localparam int BPW = BYTES_PER_WORD;
  localparam int W = BYTE_W * BPW;
  localparam int CW = $clog2(BPW + 1);
  localparam int IW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] FULL = CW'(BPW);
  localparam logic [CW-1:0] LAST = CW'(BPW - 1);
  localparam logic [IW-1:0] TLIM = IW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [W-1:0] acc, acc_a;
  logic [CW-1:0] cnt, cnt_a, lane;
  logic [IW-1:0] idle;
  logic [BPW-1:0] keep_a;
  logic pend, fire, full, want, emit, tmo, out_free;
  assign in_ready = state == FILL;
  always_comb begin
    fire = in_valid && in_ready;
    lane = LITTLE_ENDIAN != 0 ? cnt : LAST - cnt;
    acc_a = acc;
    if (fire) acc_a[lane*BYTE_W +: BYTE_W] = in_data;
    cnt_a = cnt + CW'(fire);
    tmo = TIMEOUT_CYCLES != 0 && state == FILL && cnt != '0 && !fire && idle == TLIM;
    full = cnt_a == FULL;
    want = pend || ((flush || tmo) && state == FILL && cnt_a != '0);
    out_free = !out_valid || out_ready;
    emit = out_free && (full || want);
    // shift wraps to zero on a full word, so the subtraction yields all-ones
    keep_a = (BPW'(1) << cnt_a) - BPW'(1);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FILL;
      acc <= '0;
      cnt <= '0;
      pend <= 1'b0;
      idle <= '0;
      out_data <= '0;
      out_keep <= '0;
      out_valid <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= !emit && full ? HOLD : FILL;
      acc <= emit ? '0 : acc_a;
      cnt <= emit ? '0 : cnt_a;
      pend <= !emit && want && !full;
      idle <= (fire || emit || cnt_a == '0) ? '0 :
              (state == FILL && idle != TLIM) ? idle + IW'(1) : idle;
      if (emit) begin
        out_data <= acc_a;
        out_keep <= keep_a;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && !in_ready && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_uart_word_packer.sv
// tb_uart_word_packer: directed scoreboard bench driving a little- and a big-endian packer in parallel
module tb_uart_word_packer;
  logic clk = 0, rst = 0, in_valid = 0, flush = 0, out_ready = 1;
  logic [7:0] in_data = '0;
  logic a_ready, a_valid, b_ready, b_valid;
  logic [127:0] a_data, b_data;
  logic [15:0] a_keep, b_keep, a_drop, b_drop;
  typedef struct packed {logic [127:0] d; logic [15:0] k;} word_t;
  word_t qa[$], qb[$];
  logic [7:0] cur[$];
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  uart_word_packer #(.TIMEOUT_CYCLES(100)) ua (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(a_ready),
    .flush(flush), .out_data(a_data), .out_keep(a_keep), .out_valid(a_valid),
    .out_ready(out_ready), .drop_cnt(a_drop));
  uart_word_packer #(.LITTLE_ENDIAN(0), .TIMEOUT_CYCLES(100)) ub (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(b_ready),
    .flush(flush), .out_data(b_data), .out_keep(b_keep), .out_valid(b_valid),
    .out_ready(out_ready), .drop_cnt(b_drop));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic expect_word(input int n);
    word_t wa = '0, wb = '0;
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = cur.pop_front();
      wa.d[8*i +: 8] = b;
      wb.d[8*(15-i) +: 8] = b;
      wa.k[i] = 1'b1;
      wb.k[i] = 1'b1;
    end
    qa.push_back(wa);
    qb.push_back(wb);
  endtask
  task automatic step();
    word_t w;
    if (a_valid && out_ready) begin
      chk("a_expected_word", 128'(qa.size() > 0), 128'(1));
      if (qa.size() > 0) begin
        w = qa.pop_front();
        chk("a_data", a_data, w.d);
        chk("a_keep", 128'(a_keep), 128'(w.k));
      end
    end
    if (b_valid && out_ready) begin
      chk("b_expected_word", 128'(qb.size() > 0), 128'(1));
      if (qb.size() > 0) begin
        w = qb.pop_front();
        chk("b_data", b_data, w.d);
        chk("b_keep", 128'(b_keep), 128'(w.k));
      end
    end
    if (in_valid && a_ready) cur.push_back(in_data);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic f = 1'b0);
    in_valid = 1'b1;
    in_data = b;
    flush = f;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
  endtask
  initial begin
    #1;
    chk("rst_in_ready", 128'(a_ready), 128'(1));
    chk("rst_out_valid", 128'(a_valid), 128'(0));
    chk("rst_out_data", a_data, 128'(0));
    chk("rst_out_keep", 128'(a_keep), 128'(0));
    chk("rst_drop", 128'(a_drop), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // full little-endian word, one cycle latency
    for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i));
    expect_word(16);
    chk("latency_valid", 128'(a_valid), 128'(1));
    chk("le_word", a_data, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);
    chk("be_word", b_data, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    step();
    // back-pressure: stall one word, fill acc to HOLD, drop a byte
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) send(8'hB0 + 8'(i));
    expect_word(16);
    expect_word(16);
    chk("hold_in_ready", 128'(a_ready), 128'(0));
    send(8'hD0);
    chk("drop_cnt", 128'(a_drop), 128'(1));
    out_ready = 1'b1;
    repeat (3) step();
    chk("stall_drained", 128'(qa.size() + qb.size()), 128'(0));
    // idle timeout flush after 100 idle cycles
    send(8'hB0);
    send(8'hB1);
    send(8'hB2);
    expect_word(3);
    repeat (99) step();
    chk("timeout_early", 128'(a_valid), 128'(0));
    step();
    chk("timeout_valid", 128'(a_valid), 128'(1));
    chk("timeout_keep", 128'(a_keep), 128'(16'h0007));
    chk("timeout_data", a_data, 128'h00B2B1B0);
    step();
    // flush in the same cycle as an accept
    for (int i = 1; i < 5; i++) send(8'hC0 + 8'(i));
    send(8'hC5, 1'b1);
    expect_word(5);
    chk("flush_keep", 128'(a_keep), 128'(16'h001F));
    chk("flush_lane4", 128'(a_data[39:32]), 128'(8'hC5));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (2) step();
    chk("empty_flush", 128'(a_valid), 128'(0));
    // flush pending behind a stalled word, later byte joins it
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
    expect_word(16);
    send(8'hE1);
    send(8'hE2, 1'b1);
    send(8'hE3);
    expect_word(3);
    repeat (3) step();
    chk("pending_held", 128'(a_keep), 128'(16'hFFFF));
    out_ready = 1'b1;
    repeat (3) step();
    chk("pending_drained", 128'(qa.size() + qb.size()), 128'(0));
    // reset mid-word discards partial data
    for (int i = 0; i < 7; i++) send(8'hF0 + 8'(i));
    rst = 1'b0;
    #1;
    chk("midrst_valid", 128'(a_valid), 128'(0));
    chk("midrst_drop", 128'(a_drop), 128'(0));
    cur.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) send(8'hE0 + 8'(i));
    expect_word(16);
    repeat (3) step();
    chk("final_drained", 128'(qa.size() + qb.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_word_packer.md
# uart_word_packer

Parametrised byte-to-word packer between the UART receiver and the word FIFO. It accumulates BYTES_PER_WORD received bytes into one wide word and emits it on a valid/ready interface. Byte lane order is selectable. Partial words are flushed on an explicit request or after a programmable idle timeout, with a per-byte keep mask. Bytes arriving while the block cannot accept them are counted as drops.

## Interface
- BYTE_W, default 8, width of one input byte.
- BYTES_PER_WORD, default 16, bytes per output word (≥2); word width W = BYTE_W*BYTES_PER_WORD.
- LITTLE_ENDIAN, default 1. 1: byte k occupies bits [BYTE_W*k+BYTE_W-1 : BYTE_W*k]. 0: byte 0 occupies the MSB lane.
- TIMEOUT_CYCLES, default 0, idle cycles before an automatic partial flush; 0 disables the timeout.
- DROP_CNT_W, default 16, width of the drop counter.

- clk, input, 1: single clock; all logic on its rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- in_data, input, BYTE_W: received byte.
- in_valid, input, 1: in_data valid this cycle.
- in_ready, output, 1: packer can accept a byte.
- flush, input, 1: single-cycle request to emit the current partial word.
- out_data, output, W: packed word.
- out_keep, output, BYTES_PER_WORD: bit k=1 means byte k is valid. Bit k maps to logical byte k regardless of lane order.
- out_valid, output, 1: out_data/out_keep valid.
- out_ready, input, 1: consumer accepts the word.
- drop_cnt, output, DROP_CNT_W: saturating count of bytes presented while in_ready=0.

## Operation
- Two storage stages: an accumulator (acc, cnt 0..BYTES_PER_WORD) and an output register (out_data, out_keep, out_valid).
- State machine:
  - FILL (cnt<BYTES_PER_WORD): in_ready=1.
  - HOLD (cnt==BYTES_PER_WORD, output register busy): in_ready=0.
  - Reset state is FILL with cnt=0.
- Accept occurs when in_valid && in_ready. The byte is written into lane cnt (per LITTLE_ENDIAN), and cnt increments.
- "Output free" means !out_valid || out_ready.
- Word completion: the accepting byte makes cnt reach BYTES_PER_WORD.
  - If output is free: the completed word, including the new byte, loads the output register with out_keep all-ones, cnt returns to 0, and the state stays FILL.
  - Otherwise: go to HOLD. When output becomes free, transfer and return to FILL with cnt=0.
- Partial flush trigger: (flush || timeout expiry) with cnt>0 in FILL.
  - If output is free: load cnt' bytes, where cnt' includes any byte accepted this cycle. out_keep gets the low cnt' bits set, unfilled lanes are 0, and cnt goes to 0.
  - Otherwise: the flush remains pending and is taken on the first cycle output is free. Bytes accepted meanwhile join the pending word.
  - A pending flush is cleared by the word becoming full; the full word then goes out normally.
  - flush with cnt==0 and no accept that cycle is ignored.
- Idle counter:
  - Cleared on accept and whenever cnt==0.
  - Increments each FILL cycle with cnt>0 and no accept.
  - Expiry at idle==TIMEOUT_CYCLES-1 (a flush on the TIMEOUT_CYCLES-th idle cycle).
- drop_cnt increments when in_valid && !in_ready and saturates at all-ones. The dropped byte is discarded.
- Reset mid-operation clears acc, cnt, the pending flush and the output register. Partial data is lost.

## Timing
- Reset values:
  - in_ready=1.
  - out_valid=0.
  - out_data=0.
  - out_keep=0.
  - drop_cnt=0.
- Latency: the completing byte accepted at edge n gives out_valid=1 after edge n. That is 1 cycle when output is free.
- Output holds out_data/out_keep stable while out_valid && !out_ready. out_valid clears after a handshake unless a new word loads the same edge (back-to-back words at full rate).
- in_ready is a registered function of state only. It never depends combinationally on out_ready.
- Throughput: one byte per cycle sustained when out_ready=1.

## Test plan
- Send A0..AF (LITTLE_ENDIAN=1, out_ready=1) → one word 0xAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, out_keep=0xFFFF, valid 1 cycle after the AF accept.
- Hold out_ready=0 and send 32 bytes B0..CF → word 1 (B0..BF) stalls in the output register and word 2 fills acc to HOLD, so in_ready=0. Byte D0 offered gives drop_cnt=1. Release out_ready → both words are delivered in order with no loss.
- TIMEOUT_CYCLES=100: send B0,B1,B2 then idle → after 100 idle cycles out_data=0x…00B2B1B0 and out_keep=0x0007. The next byte starts at lane 0.
- flush asserted in the same cycle as accepting C5 with cnt=4 → out_keep=0x001F and lane 4=C5. flush with cnt=0 produces no output.
- LITTLE_ENDIAN=0, send A0..AF → out_data=0xA0A1…AF, out_keep=0xFFFF.
- Assert rst after 7 bytes → out_valid=0 and drop_cnt=0. The next 16 bytes E0..EF form a clean word with no residue.
